// File: rtl/icache_line_fill.sv
// Instruction-cache line fill: fetches the four words of a missed 16-byte line from memory.
// Optional critical-word-first ordering and early critical-word output under ICACHE_LINE_FILL_CWF_EN.
module icache_line_fill #(
    parameter int MAX_WAIT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         miss_req,
    input  logic [31:0]  miss_addr,
    output logic         busy,
    output logic         mem_rd,
    output logic [31:0]  mem_addr,
    input  logic [31:0]  mem_rdata,
    input  logic         mem_ack,
    output logic [127:0] dataline,
    output logic         line_valid,
    output logic         fill_err,
    output logic         crit_valid,
    output logic [31:0]  crit_word
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t         state_q, state_d;
    logic [27:0]    base_q, base_d;
    logic [1:0]     idx_q, idx_d;
    logic [1:0]     cnt_q, cnt_d;
    logic [7:0]     wait_q, wait_d;
    logic [127:0]   dline_q, dline_d;
    logic           err_q, err_d;
    logic [1:0]     start_idx;
    logic           unused_addr_bits;

    assign unused_addr_bits = ^miss_addr[3:0];

`ifdef ICACHE_LINE_FILL_CWF_EN
    logic           cv_q, cv_d;
    logic [31:0]    cw_q, cw_d;
    assign start_idx  = miss_addr[3:2];
    assign crit_valid = cv_q;
    assign crit_word  = cw_q;
`else
    assign start_idx  = 2'b00;
    assign crit_valid = 1'b0;
    assign crit_word  = 32'h0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            wait_q  <= '0;
            dline_q <= '0;
            err_q   <= 1'b0;
`ifdef ICACHE_LINE_FILL_CWF_EN
            cv_q    <= 1'b0;
            cw_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            dline_q <= dline_d;
            err_q   <= err_d;
`ifdef ICACHE_LINE_FILL_CWF_EN
            cv_q    <= cv_d;
            cw_q    <= cw_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        dline_d = dline_q;
        err_d   = 1'b0;
`ifdef ICACHE_LINE_FILL_CWF_EN
        cv_d    = 1'b0;
        cw_d    = cw_q;
`endif
        case (state_q)
            IDLE: begin
                if (miss_req) begin
                    base_d  = miss_addr[31:4];
                    idx_d   = start_idx;
                    cnt_d   = 2'd0;
                    wait_d  = 8'd0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    dline_d[{idx_q, 5'b00000} +: 32] = mem_rdata;
                    idx_d  = idx_q + 2'd1;
                    cnt_d  = cnt_q + 2'd1;
                    wait_d = 8'd0;
`ifdef ICACHE_LINE_FILL_CWF_EN
                    if (cnt_q == 2'd0) begin
                        cw_d = mem_rdata;
                        cv_d = 1'b1;
                    end
`endif
                    if (cnt_q == 2'd3) begin
                        state_d = DONE;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    // Timeout: abort with mem_rd dropping together with the error pulse.
                    err_d   = 1'b1;
                    wait_d  = 8'd0;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign mem_rd     = (state_q == REQ);
    assign mem_addr   = {base_q, idx_q, 2'b00};
    assign line_valid = (state_q == DONE);
    assign fill_err   = err_q;
    assign dataline   = dline_q;

endmodule

// File: doc/icache_line_fill.md
Name: icache_line_fill

Overview:
- Memory-side responder for the instruction cache's miss path.
- On a miss request it fetches the four 32-bit words of the aligned 16-byte line from word-wide instruction memory over a req/ack handshake.
- It assembles the words into the 128-bit `dataline` and pulses `line_valid` so the cache can write the line.
- Sits between the cache's `hit`/`address` logic and instruction memory.

Parameters:
- MAX_WAIT, 255: cycles `mem_rd` may stay high without `mem_ack` before the fill aborts (range 1..255; 8-bit wait counter).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- miss_req  input  1  cache miss, sampled only when busy=0
- miss_addr  input  32  missing instruction byte address
- busy  output  1  fill in progress
- mem_rd  output  1  word read request to memory
- mem_addr  output  32  word address, = {line_base, idx, 2'b00}
- mem_rdata  input  32  read data, valid when mem_ack=1
- mem_ack  input  1  memory completes current read
- dataline  output  128  assembled line; word k in bits [32k+31:32k]
- line_valid  output  1  one-cycle pulse, dataline complete
- fill_err  output  1  one-cycle pulse, fill aborted on timeout
- crit_valid  output  1  critical word available (see Optional Feature)
- crit_word  output  32  critical word data

Behaviour:
- Reset values: mem_rd=0, mem_addr=0, dataline=0, busy=0, line_valid=0, fill_err=0, crit_valid=0, crit_word=0. State goes to IDLE; idx, word count and wait counter go to 0.
- rst asserted mid-fill aborts the fill at that edge. No line_valid and no fill_err are produced, and mem_rd is low in the following cycle.
- IDLE state:
  - busy=0.
  - On miss_req=1: latch line_base=miss_addr[31:4]; set idx=start index (0, or miss_addr[3:2] with the optional feature); set count=0 and wait=0; go to REQ.
- REQ state:
  - busy=1, mem_rd=1, mem_addr = {line_base, idx, 2'b00}, held stable until ack.
  - mem_ack is legal in any cycle with mem_rd=1, including the first. On ack:
    - dataline[32*idx +: 32] <= mem_rdata
    - idx <= idx+1 mod 4 (wrap-around)
    - count <= count+1
    - wait <= 0
  - If the ack completes count=3 (the 4th word): go to DONE, mem_rd=0 next cycle. Otherwise stay in REQ; the new mem_addr is presented the next cycle with mem_rd still high (back-to-back words allowed).
  - Each cycle without ack increments wait. When wait reaches MAX_WAIT with no ack: pulse fill_err for one cycle, drop mem_rd, go to IDLE. line_valid is never asserted for an aborted fill, and dataline may hold partial data.
- DONE state: line_valid=1 for exactly one cycle, busy=1, then go to IDLE.
- Minimum latency with ack every cycle:
  - miss_req sampled at edge 0
  - mem_rd high in cycles 1–4
  - words captured at edges 2–5
  - line_valid high in cycle 5
  - busy low again in cycle 6
- miss_req while busy=1 (REQ or DONE) is ignored, not queued. The cache holds miss_req until it sees line_valid or fill_err.
- mem_ack while mem_rd=0 is ignored. mem_rdata is don't-care without ack.
- dataline holds its value between fills. It is not cleared at fill start and is qualified only by line_valid.

Optional Feature:
- Macro: ICACHE_LINE_FILL_CWF_EN (critical-word-first).
- Defined:
  - Start index = miss_addr[3:2]; fetch order wraps, e.g. start 2 gives 2,3,0,1.
  - On the first ack of a fill, crit_word <= mem_rdata and crit_valid pulses for one cycle, so the pipeline can restart before line_valid.
  - crit_word holds until the next fill's first word.
- Undefined:
  - Start index is always 0 (order 0,1,2,3).
  - crit_valid and crit_word are tied to 0.
  - Ports remain present.

Test Plan:
- Reset, then miss_req with miss_addr=0x00000000. Memory acks every cycle with 0xa3a2a1a0, 0xa7a6a5a4, 0xabaaa9a8, 0xafaeadac. Expect mem_addr 0x0,0x4,0x8,0xC; line_valid in cycle 5; dataline=0xafaeadacabaaa9a8a7a6a5a4a3a2a1a0.
- miss_addr=0x00001238 with acks after 3 idle cycles each. Expect mem_addr sequence 0x1230,0x1234,0x1238,0x123C (CWF on: 0x1238,0x123C,0x1230,0x1234; crit_valid with word at 0x1238). Expect line_valid exactly once and busy=1 throughout.
- MAX_WAIT=8, memory never acks. Expect fill_err pulse exactly 8 cycles after mem_rd rises, mem_rd low next cycle, no line_valid, busy=0 afterwards.
- Second miss_req pulsed during an active fill, with a different address. Expect it ignored, mem_addr line_base unchanged; a new fill starts only after busy falls.
- rst asserted after 2 words of a fill. Expect all outputs 0 next cycle. A subsequent miss completes normally.
- mem_ack pulsed while idle. Expect no state change and dataline unchanged.
